adc_sequencer: RTL and testbench
================================

// Module: adc_sequencer
// PURPOSE
//  Initiator side of the SAR ADC Start/Done handshake. Launches conversions at a fixed
//  sample period, captures Result on each Done, averages 2**AvgLog2 samples and emits
//  one Data word with a one-cycle Valid strobe. Sits between the ADC control block and
//  downstream digital logic. Flags a stuck converter with a timeout.
// PARAMETERS
//  Bits     6   ADC result width; must match the converter's Bits
//  AvgLog2  2   log2 of samples averaged per output; 0 = pass-through
//  Period   64  clocks between Start launches (min effective: one full handshake)
//  Timeout  32  max clocks spent in any single wait state before Error
// PORTS
//  Clk     in   1              system clock, all state on posedge
//  Reset   in   1              asynchronous, active-high reset
//  Enable  in   1              level; high = run continuous sequence
//  Done    in   1              ADC conversion complete (level, from ADC)
//  Result  in   Bits           ADC result, valid while Done=1
//  Start   out  1              one-clock conversion request to ADC
//  Data    out  Bits           averaged result
//  Valid   out  1              one-clock strobe, Data updated same cycle
//  Busy    out  1              high in any state other than IDLE
//  Error   out  1              sticky timeout flag
// BEHAVIOUR
//  Reset: Start=0, Valid=0, Busy=0, Error=0, Data=0, accumulator=0, sample count=0,
//   period counter=0, state=IDLE. Reset mid-handshake abandons it immediately.
//  FSM: IDLE -> START (Enable=1 and Error=0) ; START -> WAIT_CLR after exactly 1 clock
//   (Start=1 only in START) ; WAIT_CLR -> WAIT_DONE when Done=0 ; WAIT_DONE -> HOLD when
//   Done=1 (Result captured that edge) ; HOLD -> START when period counter reaches
//   Period-1, or -> IDLE if Enable=0.
//  Period counter: cleared on entry to START, counts every clock; if Period-1 already
//   reached on entry to HOLD, START follows on the next clock.
//  Timeout: counter cleared on entry to WAIT_CLR and WAIT_DONE; reaching Timeout in
//   either -> Error=1, accumulator and count cleared, state IDLE, no Valid.
//   Error clears only on Enable=0 (next clock) or Reset.
//  Accumulator width Bits+AvgLog2, never overflows. On capture: acc+=Result, count++.
//   When count wraps to 0 (2**AvgLog2 samples): Data = (acc+Result)>>AvgLog2, Valid=1
//   for that cycle, acc cleared. AvgLog2=0: Data=Result, Valid on every capture.
//  Enable=0 in WAIT_CLR/WAIT_DONE: handshake completes (ADC cannot be aborted), the
//   sample is discarded, acc/count cleared, -> IDLE, no Valid. Enable=0 in START:
//   Start still pulses, same discard rule. Enable re-rise starts a fresh block.
//  Done=1 seen in START is ignored (stale Done from previous conversion).
// CONFIGURATION
//  ADC_SEQ_ROUND_EN defined: Data = (sum + 2**(AvgLog2-1)) >> AvgLog2, saturated to
//   2**Bits-1; no effect when AvgLog2=0. Undefined: truncating shift, no saturation.
// TESTING
//  1 ADC model Done 8 clks after Start, Result=21, defaults -> Data=21, Valid every 256
//    clks, Start every 64 clks, Error=0.
//  2 Results 10,11,11,11 -> Data=10 (truncate); with ADC_SEQ_ROUND_EN Data=11;
//    four results of 63 with rounding -> Data=63 (saturation path).
//  3 Model never raises Done -> Error=1 exactly 32 clks after WAIT_DONE entry, Busy=0,
//    no Valid; Enable low 1 clk then high -> Error=0, sequence restarts.
//  4 Enable dropped during WAIT_DONE of sample 3 -> handshake finishes, no Valid, IDLE;
//    re-enable with Result=5 -> first Data=5 after four new samples.
//  5 Period=4 with 8-clk conversion -> Start issued 1 clk after each HOLD entry.
//  6 Reset asserted in WAIT_DONE -> all outputs 0 asynchronously; after release and
//    Enable=1, first Start within 1 clk.

Source files
------------

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - SAR ADC start/done sequencer with block averaging and stuck-converter timeout
// Define ADC_SEQ_ROUND_EN for round-to-nearest, saturating averages; default truncates.
module adc_sequencer #(
  parameter int Bits    = 6,
  parameter int AvgLog2 = 2,
  parameter int Period  = 64,
  parameter int Timeout = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            done,
  input  logic [Bits-1:0] result,
  output logic            start,
  output logic [Bits-1:0] data,
  output logic            valid,
  output logic            busy,
  output logic            error
);

  localparam int AW = Bits + AvgLog2;
  localparam int CW = (AvgLog2 > 0) ? AvgLog2 : 1;
  localparam int PW = $clog2(Period + 1);
  localparam int TW = $clog2(Timeout + 1);

  localparam logic [PW-1:0] PLAST = PW'(Period - 1);
  localparam logic [TW-1:0] TLAST = TW'(Timeout - 1);
  localparam logic [CW-1:0] CLAST = CW'((1 << AvgLog2) - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_CLR, WAIT_DONE, HOLD} state_t;

  state_t          state, nxt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   sum;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   pcnt;
  logic [TW-1:0]   tcnt;
  logic            abort;
  logic            timeout;
  logic            capture;
  logic            discard;
  logic            last;
  logic            enter_start;
  logic [Bits-1:0] avg;

  assign sum         = acc + AW'(result);
  assign last        = (cnt == CLAST);
  assign capture     = (state == WAIT_DONE) && done;
  assign discard     = abort || !enable;
  assign enter_start = (nxt == START) && (state != START);
  assign timeout     = (((state == WAIT_CLR) && done) || ((state == WAIT_DONE) && !done))
                       && (tcnt == TLAST);

`ifdef ADC_SEQ_ROUND_EN
  localparam logic [AW:0] RND  = (AW+1)'((1 << AvgLog2) / 2);
  localparam logic [AW:0] DMAX = (AW+1)'((1 << Bits) - 1);
  logic [AW:0] rsum, rsh;
  assign rsum = {1'b0, sum} + RND;
  assign rsh  = rsum >> AvgLog2;
  assign avg  = (rsh > DMAX) ? '1 : Bits'(rsh);
`else
  assign avg = Bits'(sum >> AvgLog2);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (enable && !error) nxt = START;
      START:     nxt = WAIT_CLR;
      WAIT_CLR:  if (!done) nxt = WAIT_DONE;
                 else if (timeout) nxt = IDLE;
      WAIT_DONE: if (done) nxt = discard ? IDLE : HOLD;
                 else if (timeout) nxt = IDLE;
      HOLD:      if (!enable) nxt = IDLE;
                 else if (pcnt == PLAST) nxt = START;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == START);
    busy  = (state != IDLE);
  end

  // Timers saturate so long IDLE/HOLD stretches never wrap into a false expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      cnt   <= '0;
      pcnt  <= '0;
      tcnt  <= '0;
      abort <= 1'b0;
      error <= 1'b0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (state != nxt)      tcnt <= '0;
      else if (tcnt != TLAST) tcnt <= tcnt + 1'b1;

      if (enter_start)        pcnt <= '0;
      else if (pcnt != PLAST) pcnt <= pcnt + 1'b1;

      if (enter_start) abort <= 1'b0;
      else if (!enable && (state == START || state == WAIT_CLR || state == WAIT_DONE))
        abort <= 1'b1;

      if (timeout)      error <= 1'b1;
      else if (!enable) error <= 1'b0;

      // A block is only ever built from samples taken under one uninterrupted enable.
      if (timeout || (state == HOLD && !enable)) begin
        acc <= '0;
        cnt <= '0;
      end else if (capture) begin
        if (discard) begin
          acc <= '0;
          cnt <= '0;
        end else if (last) begin
          acc   <= '0;
          cnt   <= '0;
          data  <= avg;
          valid <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - randomized self-checking bench for adc_sequencer
module tb_adc_sequencer;

  localparam int NAVG = 4;
  localparam int DLY  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b0, done = 1'b0;
  logic [5:0] result = '0;
  logic       start, valid, busy, error;
  logic [5:0] data;
  logic       enable2 = 1'b0, done2 = 1'b0;
  logic [5:0] result2 = '0;
  logic       start2, valid2, busy2, error2;
  logic [5:0] data2;

  int chk_cnt = 0, pass_cnt = 0, cyc = 0;
  int res_q[$];
  int res_def = 0, cd = 0, cd2 = 0, r2 = 0;
  bit hang = 1'b0;
  int got_q[$], vcyc_q[$], scyc_q[$], got2_q[$], s2cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adc_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .done(done), .result(result),
    .start(start), .data(data), .valid(valid), .busy(busy), .error(error)
  );

  adc_sequencer #(.Period(4)) dut_p4 (
    .clk(clk), .reset(reset), .enable(enable2), .done(done2), .result(result2),
    .start(start2), .data(data2), .valid(valid2), .busy(busy2), .error(error2)
  );

  // Converter models: Done drops on Start and rises DLY clocks later with a new result.
  always @(negedge clk) begin
    if (start) begin
      done = 1'b0;
      cd = DLY;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && !hang) begin
        if (res_q.size() > 0) result = 6'(res_q.pop_front());
        else result = 6'(res_def);
        done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (start2) begin
      done2 = 1'b0;
      cd2 = DLY;
    end else if (cd2 > 0) begin
      cd2--;
      if (cd2 == 0) begin
        result2 = 6'(r2);
        done2 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(int'(data));
      vcyc_q.push_back(cyc);
    end
    if (start) scyc_q.push_back(cyc);
    if (valid2) got2_q.push_back(int'(data2));
    if (start2) s2cyc_q.push_back(cyc);
  end

  function automatic int exp_avg(int s);
    int r;
`ifdef ADC_SEQ_ROUND_EN
    r = (s + NAVG / 2) / NAVG;
    if (r > 63) r = 63;
`else
    r = s / NAVG;
`endif
    return r;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    res_q.delete();
    got_q.delete();
    vcyc_q.delete();
    scyc_q.delete();
    got2_q.delete();
    s2cyc_q.delete();
  endtask

  task automatic go_idle();
    enable = 1'b0;
    for (int k = 0; k < 50 && busy; k++) tick();
    tick();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL go_idle_busy got %0b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    tick(3);
    chk_cnt++; if (start !== 1'b0) $display("FAIL reset_start got %0b want 0", start); else pass_cnt++;
    chk_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (error !== 1'b0) $display("FAIL reset_error got %0b want 0", error); else pass_cnt++;
    chk_cnt++; if (data !== 6'd0) $display("FAIL reset_data got %0d want 0", data); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_steady();
    clear_q();
    res_def = 21;
    enable = 1'b1;
    for (int k = 0; k < 1000 && got_q.size() < 3; k++) tick();
    chk_cnt++;
    if (got_q.size() < 3) $display("FAIL steady_count got %0d want 3", got_q.size()); else pass_cnt++;
    foreach (got_q[i]) begin
      chk_cnt++;
      if (got_q[i] != 21) $display("FAIL steady_data[%0d] got %0d want 21", i, got_q[i]); else pass_cnt++;
    end
    for (int i = 1; i < vcyc_q.size(); i++) begin
      chk_cnt++;
      if (vcyc_q[i] - vcyc_q[i-1] != 256)
        $display("FAIL steady_valid_gap[%0d] got %0d want 256", i, vcyc_q[i] - vcyc_q[i-1]);
      else pass_cnt++;
    end
    for (int i = 1; i < scyc_q.size(); i++) begin
      chk_cnt++;
      if (scyc_q[i] - scyc_q[i-1] != 64)
        $display("FAIL steady_start_gap[%0d] got %0d want 64", i, scyc_q[i] - scyc_q[i-1]);
      else pass_cnt++;
    end
    chk_cnt++; if (error !== 1'b0) $display("FAIL steady_error got %0b want 0", error); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_random_average();
    int exp_q[$];
    int s, v;
    clear_q();
    res_def = 0;
    for (int b = 0; b < 3; b++) begin
      s = 0;
      for (int j = 0; j < NAVG; j++) begin
        v = $urandom_range(0, 63);
        res_q.push_back(v);
        s += v;
      end
      exp_q.push_back(exp_avg(s));
    end
    enable = 1'b1;
    for (int k = 0; k < 1000 && got_q.size() < 3; k++) tick();
    chk_cnt++;
    if (got_q.size() < 3) $display("FAIL random_count got %0d want 3", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] != exp_q[i]) $display("FAIL random_data[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    go_idle();
  endtask

  task automatic test_rounding();
    int e0, e1;
    clear_q();
    res_q = '{10, 11, 11, 11, 63, 63, 63, 63};
    e0 = exp_avg(43);
    e1 = exp_avg(252);
    enable = 1'b1;
    for (int k = 0; k < 1000 && got_q.size() < 2; k++) tick();
    chk_cnt++;
    if (got_q.size() < 2) $display("FAIL round_count got %0d want 2", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 2) begin
      chk_cnt++; if (got_q[0] != e0) $display("FAIL round_mixed got %0d want %0d", got_q[0], e0); else pass_cnt++;
      chk_cnt++; if (got_q[1] != e1) $display("FAIL round_full got %0d want %0d", got_q[1], e1); else pass_cnt++;
    end
    go_idle();
  endtask

  task automatic test_timeout();
    int s;
    clear_q();
    hang = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 10 && scyc_q.size() < 1; k++) tick();
    chk_cnt++;
    if (scyc_q.size() < 1) $display("FAIL tmo_start got none want 1");
    else begin
      pass_cnt++;
      s = scyc_q[0];
      for (int k = 0; k < 100 && cyc < s + 33; k++) tick();
      chk_cnt++; if (error !== 1'b0) $display("FAIL tmo_early_error got %0b want 0", error); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL tmo_early_busy got %0b want 1", busy); else pass_cnt++;
      tick();
      chk_cnt++; if (error !== 1'b1) $display("FAIL tmo_error got %0b want 1", error); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL tmo_busy got %0b want 0", busy); else pass_cnt++;
      tick(5);
      chk_cnt++;
      if (scyc_q.size() != 1 || busy !== 1'b0)
        $display("FAIL tmo_stays_idle starts %0d busy %0b want 1 and 0", scyc_q.size(), busy);
      else pass_cnt++;
      chk_cnt++; if (got_q.size() != 0) $display("FAIL tmo_valid got %0d want 0", got_q.size()); else pass_cnt++;
    end
    hang = 1'b0;
    enable = 1'b0;
    tick();
    chk_cnt++; if (error !== 1'b0) $display("FAIL tmo_clear got %0b want 0", error); else pass_cnt++;
    enable = 1'b1;
    tick();
    chk_cnt++; if (start !== 1'b1) $display("FAIL tmo_restart got %0b want 1", start); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_abort();
    clear_q();
    res_def = 60;
    enable = 1'b1;
    for (int k = 0; k < 400 && scyc_q.size() < 3; k++) tick();
    tick(3);
    enable = 1'b0;
    tick();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_hold got %0b want 1", busy); else pass_cnt++;
    for (int k = 0; k < 30 && busy; k++) tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_idle got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (got_q.size() != 0) $display("FAIL abort_valid got %0d want 0", got_q.size()); else pass_cnt++;
    clear_q();
    res_def = 5;
    enable = 1'b1;
    for (int k = 0; k < 400 && got_q.size() < 1; k++) tick();
    chk_cnt++;
    if (got_q.size() < 1) $display("FAIL abort_resume got none want 1 word");
    else if (got_q[0] != 5) $display("FAIL abort_resume_data got %0d want 5", got_q[0]);
    else pass_cnt++;
    chk_cnt++;
    if (scyc_q.size() != NAVG) $display("FAIL abort_fresh_block got %0d starts want %0d", scyc_q.size(), NAVG);
    else pass_cnt++;
    go_idle();
  endtask

  task automatic test_period4();
    clear_q();
    r2 = $urandom_range(0, 63);
    enable2 = 1'b1;
    for (int k = 0; k < 200 && s2cyc_q.size() < 6; k++) tick();
    chk_cnt++; if (busy2 !== 1'b1) $display("FAIL p4_busy got %0b want 1", busy2); else pass_cnt++;
    for (int i = 1; i < s2cyc_q.size(); i++) begin
      chk_cnt++;
      if (s2cyc_q[i] - s2cyc_q[i-1] != DLY + 2)
        $display("FAIL p4_start_gap[%0d] got %0d want %0d", i, s2cyc_q[i] - s2cyc_q[i-1], DLY + 2);
      else pass_cnt++;
    end
    chk_cnt++;
    if (got2_q.size() < 1) $display("FAIL p4_count got 0 want 1"); else pass_cnt++;
    foreach (got2_q[i]) begin
      chk_cnt++;
      if (got2_q[i] != r2) $display("FAIL p4_data[%0d] got %0d want %0d", i, got2_q[i], r2); else pass_cnt++;
    end
    chk_cnt++; if (error2 !== 1'b0) $display("FAIL p4_error got %0b want 0", error2); else pass_cnt++;
    enable2 = 1'b0;
    tick(20);
  endtask

  task automatic test_reset_mid();
    clear_q();
    res_def = 9;
    enable = 1'b1;
    for (int k = 0; k < 100 && scyc_q.size() < 1; k++) tick();
    tick(4);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL rmid_pre_busy got %0b want 1", busy); else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++; if (start !== 1'b0) $display("FAIL rmid_start got %0b want 0", start); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (valid !== 1'b0) $display("FAIL rmid_valid got %0b want 0", valid); else pass_cnt++;
    chk_cnt++; if (data !== 6'd0) $display("FAIL rmid_data got %0d want 0", data); else pass_cnt++;
    chk_cnt++; if (error !== 1'b0) $display("FAIL rmid_error got %0b want 0", error); else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    chk_cnt++; if (start !== 1'b1) $display("FAIL rmid_restart got %0b want 1", start); else pass_cnt++;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_random_average();
    test_rounding();
    test_timeout();
    test_abort();
    test_period4();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
